read_sequencer: RTL and testbench

- Top-level scheduler for one RGBY-ROM read pass.
- Homes the carriage against the limit switch, then steps row by row, issuing move commands to the stepper step engine and start pulses to the nib selector.
- Counts rows and flags completion or fault to the host/UI logic.
- Sits above the step-pulse engine and the selector. It is the only block that drives their command inputs.

---
 rtl/read_pkg.sv | 31 +++
 rtl/read_sequencer_if.sv | 33 +++
 rtl/timeout_counter.sv | 24 ++
 rtl/read_sequencer.sv | 138 +++++++++++++
 tb/tb_read_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/read_pkg.sv
// Shared definitions for the RGBY-ROM read path: sequencer states, carriage
// direction and fault codes, common to the sequencer, step engine and selector.
package read_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HOME_CHECK,
        HOME_WAIT,
        FIRST_MOVE,
        MOVE_WAIT,
        SCAN_START,
        SCAN_WAIT,
        ADVANCE,
        FINISHED,
        ERROR
    } seqState_t;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_HOME_TIMEOUT = 2'd1,
        ERR_SCAN_TIMEOUT = 2'd2
    } errCode_t;

    function automatic logic isBusy(input seqState_t s);
        return !(s inside {IDLE, FINISHED, ERROR});
    endfunction

endpackage

// File: rtl/read_sequencer_if.sv
// Command/status bundle between the host side, the read sequencer and the
// step engine / nib selector it drives.
interface read_sequencer_if #(
    parameter int STEP_W = 16,
    parameter int ROW_W  = 8
);
    logic              start;
    logic              abort;
    logic              limitSwitch;
    logic              moveDone;
    logic              selectorComplete;
    logic              moveCmd;
    logic [STEP_W-1:0] moveSteps;
    logic              moveDir;
    logic              moveAbort;
    logic              startSelector;
    logic [ROW_W-1:0]  rowIndex;
    logic              busy;
    logic              done;
    logic [1:0]        errorCode;

    modport slave (
        input  start, abort, limitSwitch, moveDone, selectorComplete,
        output moveCmd, moveSteps, moveDir, moveAbort, startSelector,
               rowIndex, busy, done, errorCode
    );

    modport master (
        output start, abort, limitSwitch, moveDone, selectorComplete,
        input  moveCmd, moveSteps, moveDir, moveAbort, startSelector,
               rowIndex, busy, done, errorCode
    );
endinterface

// File: rtl/timeout_counter.sv
// Clearable, enabled up-counter; expire is high in the cycle whose increment
// brings the count to TERMINAL, so the owner reacts on that same edge.
module timeout_counter #(
    parameter int               WIDTH    = 24,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign expire = enable && (count == TERMINAL - WIDTH'(1));
endmodule

// File: rtl/read_sequencer.sv
// Pass scheduler for the RGBY-ROM reader: homes the carriage on the limit
// switch, then moves to each row and hands it to the nib selector.
module read_sequencer
    import read_pkg::*;
#(
    parameter int          NUM_ROWS        = 16,
    parameter int          FIRST_ROW_STEPS = 550,
    parameter int          ROW_PITCH_STEPS = 300,
    parameter int          HOME_MAX_STEPS  = 20000,
    parameter logic [23:0] SCAN_TIMEOUT    = 24'd8000000,
    parameter int          STEP_W          = 16,
    parameter int          ROW_W           = 8
) (
    input  logic            clk,
    input  logic            reset,
    read_sequencer_if.slave bus
);
    localparam logic [STEP_W-1:0] HOME_LIMIT  = STEP_W'(HOME_MAX_STEPS);
    localparam logic [STEP_W-1:0] FIRST_STEPS = STEP_W'(FIRST_ROW_STEPS);
    localparam logic [STEP_W-1:0] PITCH_STEPS = STEP_W'(ROW_PITCH_STEPS);
    localparam logic [STEP_W-1:0] ONE_STEP    = STEP_W'(1);
    localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(NUM_ROWS - 1);

    seqState_t         state;
    logic              limMeta;
    logic              limSync;
    logic [STEP_W-1:0] homeCount;
    logic              scanExpire;

    timeout_counter #(
        .WIDTH   (24),
        .TERMINAL(SCAN_TIMEOUT)
    ) scanWatchdog (
        .clk   (clk),
        .reset (reset),
        .clear (state == SCAN_START),
        .enable(state == SCAN_WAIT),
        .expire(scanExpire)
    );

    assign bus.busy = isBusy(state);
    assign bus.done = (state == FINISHED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            limMeta           <= 1'b0;
            limSync           <= 1'b0;
            homeCount         <= '0;
            bus.moveCmd       <= 1'b0;
            bus.moveSteps     <= '0;
            bus.moveDir       <= DOWN;
            bus.moveAbort     <= 1'b0;
            bus.startSelector <= 1'b0;
            bus.rowIndex      <= '0;
            bus.errorCode     <= ERR_NONE;
        end else begin
            // NOTE: the first flop may go metastable; only the second is ever decoded.
            limMeta <= bus.limitSwitch;
            limSync <= limMeta;

            // NOTE: non-blocking defaults, overridden further down when a command fires,
            // make every command output a clean one-cycle pulse.
            bus.moveCmd       <= 1'b0;
            bus.moveAbort     <= 1'b0;
            bus.startSelector <= 1'b0;

            if (bus.abort && isBusy(state)) begin
                state         <= IDLE;
                bus.moveAbort <= 1'b1;
            end else begin
                unique case (state)
                    IDLE, FINISHED, ERROR: begin
                        if (bus.start) begin
                            bus.rowIndex  <= '0;
                            homeCount     <= '0;
                            bus.errorCode <= ERR_NONE;
                            state         <= HOME_CHECK;
                        end
                    end
                    HOME_CHECK: begin
                        if (limSync) begin
                            state <= FIRST_MOVE;
                        end else if (homeCount == HOME_LIMIT) begin
                            bus.errorCode <= ERR_HOME_TIMEOUT;
                            state         <= ERROR;
                        end else begin
                            bus.moveCmd   <= 1'b1;
                            bus.moveSteps <= ONE_STEP;
                            bus.moveDir   <= UP;
                            state         <= HOME_WAIT;
                        end
                    end
                    HOME_WAIT: begin
                        if (bus.moveDone) begin
                            if (homeCount != HOME_LIMIT) homeCount <= homeCount + ONE_STEP;
                            state <= HOME_CHECK;
                        end
                    end
                    FIRST_MOVE: begin
                        bus.moveCmd   <= 1'b1;
                        bus.moveSteps <= FIRST_STEPS;
                        bus.moveDir   <= DOWN;
                        state         <= MOVE_WAIT;
                    end
                    MOVE_WAIT: begin
                        if (bus.moveDone) state <= SCAN_START;
                    end
                    SCAN_START: begin
                        bus.startSelector <= 1'b1;
                        state             <= SCAN_WAIT;
                    end
                    SCAN_WAIT: begin
                        // A watchdog expiry beats a completion arriving on the same edge.
                        if (scanExpire) begin
                            bus.errorCode <= ERR_SCAN_TIMEOUT;
                            state         <= ERROR;
                        end else if (bus.selectorComplete) begin
                            if (bus.rowIndex == LAST_ROW) begin
                                state <= FINISHED;
                            end else begin
                                bus.rowIndex <= bus.rowIndex + ROW_W'(1);
                                state        <= ADVANCE;
                            end
                        end
                    end
                    ADVANCE: begin
                        bus.moveCmd   <= 1'b1;
                        bus.moveSteps <= PITCH_STEPS;
                        bus.moveDir   <= DOWN;
                        state         <= MOVE_WAIT;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_read_sequencer.sv
// Randomised bench for read_sequencer: a responder plays step engine, selector
// and limit switch; each pass is judged against the move/scan list it should produce.
module tb_read_sequencer;
    import read_pkg::*;

    localparam int NUM_ROWS = 3;
    localparam int FIRST    = 550;
    localparam int PITCH    = 300;
    localparam int HOME_MAX = 6;
    localparam int TIMEOUT  = 100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    read_sequencer_if #(.STEP_W(16), .ROW_W(8)) bus ();

    read_sequencer #(
        .NUM_ROWS       (NUM_ROWS),
        .FIRST_ROW_STEPS(FIRST),
        .ROW_PITCH_STEPS(PITCH),
        .HOME_MAX_STEPS (HOME_MAX),
        .SCAN_TIMEOUT   (24'(TIMEOUT)),
        .STEP_W         (16),
        .ROW_W          (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Knobs owned by the scenario process.
    int passId       = 0;
    int switchAfter  = 0;   // home moves before the switch closes; 0 = already home, -1 = never
    bit holdSelector = 1'b0;
    bit noiseOn      = 1'b0;

    // Observations owned by the responder process, cleared on each new pass.
    logic [16:0] cmdLog[$];
    int          scanRows[$];
    int          selCount, abortCount, firstCmdCyc, lastScanCyc, errCyc;

    initial begin : responder
        int          doneWait = 0;
        int          selWait  = 0;
        int          homeSeen = 0;
        int          seenPass = -1;
        logic [1:0]  prevErr  = 2'd0;
        logic [16:0] lastCmd  = '0;
        bus.moveDone         = 1'b0;
        bus.selectorComplete = 1'b0;
        bus.limitSwitch      = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.moveDone         = 1'b0;
            bus.selectorComplete = 1'b0;
            if (passId != seenPass) begin
                seenPass = passId;
                cmdLog.delete();
                scanRows.delete();
                selCount    = 0;
                abortCount  = 0;
                firstCmdCyc = -1;
                lastScanCyc = -1;
                errCyc      = -1;
                homeSeen    = 0;
                doneWait    = 0;
                selWait     = 0;
                bus.limitSwitch = (switchAfter == 0);
            end
            if (bus.moveAbort) begin
                abortCount++;
                doneWait = 0;
                selWait  = 0;
            end
            if (bus.moveCmd) begin
                if (cmdLog.size() == 0) firstCmdCyc = cyc;
                lastCmd = {bus.moveDir, bus.moveSteps};
                cmdLog.push_back(lastCmd);
                if (bus.moveDir == UP) begin
                    homeSeen++;
                    if (homeSeen == switchAfter) bus.limitSwitch = 1'b1;
                end else begin
                    bus.limitSwitch = 1'b0;
                end
                doneWait = $urandom_range(2, 5);
            end else if (doneWait > 0) begin
                doneWait--;
                if (doneWait == 0) bus.moveDone = 1'b1;
            end
            if (bus.startSelector) begin
                selCount++;
                scanRows.push_back(int'(bus.rowIndex));
                lastScanCyc = cyc;
                check("command held during scan", {bus.moveDir, bus.moveSteps}, lastCmd);
                selWait = holdSelector ? 0 : $urandom_range(1, 6);
            end else if (selWait > 0) begin
                selWait--;
                if (selWait == 0) bus.selectorComplete = 1'b1;
            end
            // Stray pulses only while nothing is outstanding: the sequencer must ignore them.
            if (noiseOn && doneWait == 0 && !bus.moveDone && $urandom_range(0, 7) == 0)
                bus.moveDone = 1'b1;
            if (noiseOn && !holdSelector && selWait == 0 && !bus.selectorComplete &&
                $urandom_range(0, 7) == 0)
                bus.selectorComplete = 1'b1;
            if (prevErr == 2'd0 && bus.errorCode != 2'd0 && errCyc < 0) errCyc = cyc;
            prevErr = bus.errorCode;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic newPass(input int sw, input bit hold, input bit noise);
        switchAfter  = sw;
        holdSelector = hold;
        noiseOn      = noise;
        passId++;
        tick(3);
    endtask

    task automatic pulseStart(output int t);
        @(negedge clk);
        bus.start = 1'b1;
        t = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulseAbort();
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
    endtask

    task automatic waitIdle(input int limit, input string tag);
        int k = 0;
        while (bus.busy && k < limit) begin
            @(negedge clk);
            k++;
        end
        check({tag, " settles within bound"}, bus.busy, 1'b0);
    endtask

    task automatic waitMoves(input int n, input string tag);
        int k = 0;
        while (cmdLog.size() < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        check({tag, " move issued within bound"}, cmdLog.size() >= n, 1'b1);
    endtask

    // Expected command list: homeMoves single UP steps, then rowMoves DOWN moves
    // (first to row 0 centre, the rest one pitch each).
    task automatic checkMoves(input string tag, input int homeMoves, input int rowMoves);
        logic [16:0] exp[$];
        for (int i = 0; i < homeMoves; i++) exp.push_back({UP, 16'd1});
        if (rowMoves > 0) exp.push_back({DOWN, 16'(FIRST)});
        for (int i = 1; i < rowMoves; i++) exp.push_back({DOWN, 16'(PITCH)});
        check({tag, " move count"}, cmdLog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < cmdLog.size(); i++)
            check($sformatf("%s move %0d", tag, i), cmdLog[i], exp[i]);
    endtask

    task automatic runPass(input string tag, input int sw, input bit noise, input bit stray);
        int t0;
        int dummy;
        newPass(sw, 1'b0, noise);
        pulseStart(t0);
        if (stray) begin
            tick($urandom_range(5, 30));
            if (bus.busy) pulseStart(dummy);
        end
        waitIdle(3000, tag);
        checkMoves(tag, sw, NUM_ROWS);
        check({tag, " scans"}, selCount, NUM_ROWS);
        for (int i = 0; i < scanRows.size(); i++)
            check($sformatf("%s scan %0d row", tag, i), scanRows[i], i);
        check({tag, " done"}, bus.done, 1'b1);
        check({tag, " final row"}, bus.rowIndex, NUM_ROWS - 1);
        check({tag, " error code"}, bus.errorCode, 2'd0);
        check({tag, " no abort"}, abortCount, 0);
        if (sw > 0) check({tag, " start latency"}, firstCmdCyc - t0, 2);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin : scenario
        int t0;
        int sw;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        reset     = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(1);
        check("reset busy",          bus.busy,          1'b0);
        check("reset done",          bus.done,          1'b0);
        check("reset errorCode",     bus.errorCode,     2'd0);
        check("reset rowIndex",      bus.rowIndex,      8'd0);
        check("reset moveSteps",     bus.moveSteps,     16'd0);
        check("reset moveDir",       bus.moveDir,       1'b0);
        check("reset moveCmd",       bus.moveCmd,       1'b0);
        check("reset moveAbort",     bus.moveAbort,     1'b0);
        check("reset startSelector", bus.startSelector, 1'b0);

        runPass("already home", 0, 1'b0, 1'b0);

        pulseAbort();
        tick(3);
        check("idle abort ignored", abortCount, 0);
        check("idle abort keeps done", bus.done, 1'b1);

        runPass("five home steps", 5, 1'b0, 1'b0);
        runPass("switch at home limit", HOME_MAX, 1'b0, 1'b0);

        for (int p = 0; p < 6; p++) begin
            runPass($sformatf("random pass %0d", p), $urandom_range(0, HOME_MAX), 1'b1, 1'b1);
        end

        newPass(-1, 1'b0, 1'b0);
        pulseStart(t0);
        waitIdle(500, "home fault");
        checkMoves("home fault", HOME_MAX, 0);
        check("home fault errorCode", bus.errorCode, 2'd1);
        check("home fault done", bus.done, 1'b0);
        tick(20);
        check("home fault stays quiet", cmdLog.size(), HOME_MAX);

        sw = $urandom_range(0, 3);
        newPass(sw, 1'b1, 1'b0);
        pulseStart(t0);
        waitIdle(600, "scan timeout");
        check("scan timeout errorCode", bus.errorCode, 2'd2);
        check("scan timeout distance", errCyc - lastScanCyc, TIMEOUT);
        check("scan timeout scans", selCount, 1);
        check("scan timeout row", bus.rowIndex, 8'd0);
        checkMoves("scan timeout", sw, 1);

        newPass(2, 1'b0, 1'b0);
        pulseStart(t0);
        waitMoves(2 + 2, "abort row 1");
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        tick(2);
        check("abort busy", bus.busy, 1'b0);
        check("abort done", bus.done, 1'b0);
        check("abort errorCode", bus.errorCode, 2'd0);
        check("abort rowIndex held", bus.rowIndex, 8'd1);
        tick(10);
        check("abort single pulse", abortCount, 1);
        check("abort no further moves", cmdLog.size(), 4);
        runPass("rehome after abort", 3, 1'b0, 1'b0);

        newPass(0, 1'b1, 1'b0);
        pulseStart(t0);
        begin
            int k = 0;
            while (selCount < 1 && k < 500) begin
                @(negedge clk);
                k++;
            end
        end
        check("abort+start reached scan", selCount, 1);
        tick(3);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abort+start busy", bus.busy, 1'b0);
        tick(6);
        check("abort+start stays idle", bus.busy, 1'b0);
        check("abort+start no move", cmdLog.size(), 1);
        check("abort+start abort pulses", abortCount, 1);
        check("abort+start errorCode", bus.errorCode, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
